// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART transmit path
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer and transmitter-facing signals of uart_tx_fifo
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    logic              s_valid;
    logic              s_ready;
    logic [BYTE_W-1:0] s_data;
    logic              flush;
    logic              tx_busy;
    logic              tx_enable;
    logic [BYTE_W-1:0] tx_data;
    logic [AW:0]       fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    modport master (
        output s_valid, s_data, flush, tx_busy,
        input  s_ready, tx_enable, tx_data, fifo_count, fifo_empty, fifo_full
    );

    modport slave (
        input  s_valid, s_data, flush, tx_busy,
        output s_ready, tx_enable, tx_data, fifo_count, fifo_empty, fifo_full
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - circular DEPTH x byte FIFO with push/pop/flush
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [BYTE_W-1:0] i_wdata,
    output logic [BYTE_W-1:0] o_rdata,
    output logic [AW:0]       o_count,
    output logic              o_empty,
    output logic              o_full
);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));

    // flush wins over both a coincident push and a coincident pop
    assign w_push = i_push && !w_full && !i_flush;
    assign w_pop  = i_pop && !w_empty && !i_flush;

    // storage is deliberately left without reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // pointers wrap naturally at AW bits; count tracks push minus pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte buffer and one-at-a-time issue controller for the UART transmitter
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          resetn,
    uart_tx_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]        r_state;
    logic              r_tx_enable;
    logic [BYTE_W-1:0] r_tx_data;
    logic [BYTE_W-1:0] w_rdata;
    logic [AW:0]       w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    // s_ready comes from the registered count only, so a full FIFO never bypasses
    assign w_push = bus.s_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && !w_empty && !bus.tx_busy && !bus.flush;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_wdata (bus.s_data),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // issue FSM: one-cycle enable, then follow the transmitter's busy rise and fall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_tx_enable <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data   <= w_rdata;
                        r_tx_enable <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_tx_enable <= 1'b0;
                    r_state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx_enable <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready    = !w_full;
    assign bus.tx_enable  = r_tx_enable;
    assign bus.tx_data    = r_tx_data;
    assign bus.fifo_count = w_count;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a modelled transmitter
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    int   busy_len   = 8;
    assign bus.tx_busy = force_busy | model_busy;

    logic [7:0] q[$];
    int   total   = 0;
    int   bad     = 0;
    bit   mon_en  = 1'b0;
    bit   prev_en = 1'b0;
    int   en_seen = 0;
    logic [7:0] exp_b;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every enable must carry the oldest outstanding byte; status tracks the model queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.tx_enable) begin
                en_seen++;
                chk("enable_one_cycle", int'(prev_en), 0);
                if (q.size() == 0) begin
                    chk("unexpected_enable", 1, 0);
                end else begin
                    exp_b = q.pop_front();
                    chk("tx_data", int'(bus.tx_data), int'(exp_b));
                end
            end
            prev_en = bus.tx_enable;
            chk("fifo_count", int'(bus.fifo_count), q.size());
            chk("fifo_empty", int'(bus.fifo_empty), int'(q.size() == 0));
            chk("fifo_full", int'(bus.fifo_full), int'(q.size() == DEPTH));
            chk("s_ready", int'(bus.s_ready), int'(q.size() < DEPTH));
        end
    end

    // transmitter model: busy rises the cycle after it samples enable
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_enable && resetn) begin
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        bit acc;
        @(negedge clk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        acc = (q.size() < DEPTH) && !bus.flush;
        @(posedge clk);
        if (acc) q.push_back(d);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic flush_with(input logic [7:0] d);
        @(negedge clk);
        #1;
        bus.flush   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(posedge clk);
        q.delete();
        #1;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int quiet = 0;
        int k = 0;
        while (quiet < 4 && k < 5000) begin
            @(negedge clk);
            k++;
            if (q.size() == 0 && !bus.tx_busy && !bus.tx_enable) quiet++;
            else quiet = 0;
        end
        chk("drain_done", int'(quiet >= 4), 1);
    endtask

    task automatic wait_model_idle();
        int k = 0;
        while (model_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("model_idle", int'(model_busy), 0);
    endtask

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int en0;
        int k;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.flush   = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_s_ready", int'(bus.s_ready), 1);
        chk("rst_empty", int'(bus.fifo_empty), 1);
        chk("rst_full", int'(bus.fifo_full), 0);
        chk("rst_count", int'(bus.fifo_count), 0);
        chk("rst_tx_enable", int'(bus.tx_enable), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);
        resetn = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_no_enable", en_seen, 0);

        // single byte latency: enable visible in the second cycle after the push edge
        busy_len = 50;
        en0 = en_seen;
        push_byte(8'hA5);
        @(negedge clk);
        chk("lat_cycle1_enable", int'(bus.tx_enable), 0);
        @(negedge clk);
        chk("lat_cycle2_enable", int'(bus.tx_enable), 1);
        chk("lat_cycle2_data", int'(bus.tx_data), 8'hA5);
        @(negedge clk);
        chk("lat_cycle3_enable", int'(bus.tx_enable), 0);
        repeat (55) @(negedge clk);
        chk("single_enables", en_seen - en0, 1);
        chk("single_count", int'(bus.fifo_count), 0);

        // fill to full while the line is busy, reject the extra byte, then drain and wrap
        busy_len = 4;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        @(negedge clk);
        #1;
        chk("fill_full", int'(bus.fifo_full), 1);
        chk("fill_s_ready", int'(bus.s_ready), 0);
        push_byte(8'hFF);
        @(negedge clk);
        #1;
        chk("fill_count", int'(bus.fifo_count), 16);
        en0 = en_seen;
        force_busy = 1'b0;
        drain();
        chk("fill_enables", en_seen - en0, 16);
        for (int i = 16; i < 32; i++) push_byte(8'(i));
        drain();

        // simultaneous push and pop keeps count steady
        force_busy = 1'b1;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        @(negedge clk);
        #1;
        force_busy  = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        @(posedge clk);
        q.push_back(8'h55);
        #1 bus.s_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("pushpop_count", int'(bus.fifo_count), 3);
        drain();

        // flush during an active frame: queue and coincident push dropped, frame completes
        busy_len = 40;
        push_byte(8'h11);
        k = 0;
        while (!model_busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("flush_frame_started", int'(model_busy), 1);
        for (int i = 0; i < 5; i++) push_byte(8'(8'h61 + i));
        @(negedge clk);
        #1;
        chk("flush_pre_count", int'(bus.fifo_count), 5);
        en0 = en_seen;
        flush_with(8'h22);
        @(negedge clk);
        #1;
        chk("flush_count", int'(bus.fifo_count), 0);
        wait_model_idle();
        repeat (20) @(negedge clk);
        chk("flush_no_enable", en_seen - en0, 0);

        // reset while the enable is high
        busy_len = 6;
        push_byte(8'hA5);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.tx_enable && k < 10);
        chk("issue_seen", int'(bus.tx_enable), 1);
        #2 resetn = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("reset_async_enable", int'(bus.tx_enable), 0);
        q.delete();
        @(negedge clk);
        chk("reset_count", int'(bus.fifo_count), 0);
        chk("reset_tx_data", int'(bus.tx_data), 0);
        resetn = 1'b1;
        wait_model_idle();
        prev_en = 1'b0;
        mon_en  = 1'b1;
        push_byte(8'h3C);
        @(negedge clk);
        chk("post_reset_lat1", int'(bus.tx_enable), 0);
        @(negedge clk);
        chk("post_reset_lat2", int'(bus.tx_enable), 1);
        drain();

        // randomized traffic against the scoreboard
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            busy_len = $urandom_range(2, 12);
            if (r < 60) begin
                push_byte(8'($urandom));
            end else if (r < 64) begin
                flush_with(8'($urandom));
            end else if (r < 72) begin
                @(negedge clk);
                #1 force_busy = ~force_busy;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        #1 force_busy = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and issue controller sitting directly upstream of the UART transmitter.
- Accepts bytes from the system side over a valid/ready handshake and stores them in a circular FIFO.
- Hands bytes to the transmitter one at a time using its tx_enable / tx_data / tx_busy interface.
- Lets software-side producers burst several bytes without tracking per-byte line timing.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset, asynchronous, active-low.
- s_valid  input  1  producer has a byte on s_data.
- s_ready  output  1  FIFO can accept a byte this cycle.
- s_data  input  8  byte to enqueue.
- flush  input  1  synchronous discard of all queued bytes.
- tx_busy  input  1  transmitter busy, from the UART transmitter.
- tx_enable  output  1  one-cycle request to the transmitter.
- tx_data  output  8  byte presented to the transmitter.
- fifo_count  output  AW+1  number of queued bytes.
- fifo_empty  output  1  fifo_count == 0.
- fifo_full  output  1  fifo_count == DEPTH.

Behaviour:
- Reset values (asynchronous):
  - All pointers, fifo_count, tx_data and tx_enable reset to 0.
  - State resets to IDLE.
  - Storage array is not reset.
- Reset output values:
  - s_ready = 1.
  - fifo_empty = 1.
  - fifo_full = 0.
- Handshake and push:
  - s_ready = !fifo_full, combinational from registered count; no full-bypass.
  - Push occurs when s_valid && s_ready.
  - Write to mem[wr_ptr]; wr_ptr increments modulo DEPTH and wraps naturally at AW bits.
- Pop:
  - Occurs only in IDLE when !fifo_empty && !tx_busy && !flush.
  - On pop, tx_data <= mem[rd_ptr] and rd_ptr increments.
  - Same edge: tx_enable <= 1, state -> ISSUE.
- Count:
  - Increments on push only, decrements on pop only, unchanged on both.
  - Push and pop in the same cycle are legal whenever count is between 1 and DEPTH-1.
- FSM states (tx_enable is registered):
  - IDLE -> ISSUE on pop.
  - ISSUE: tx_enable is high for exactly this one cycle. Next state WAIT_BUSY; tx_enable <= 0.
  - WAIT_BUSY: wait for tx_busy == 1, then WAIT_DONE. The transmitter raises busy on the cycle after it samples enable, so normally WAIT_BUSY lasts 1 cycle.
  - WAIT_DONE: wait for tx_busy == 0, then IDLE.
- tx_data stability: held stable from ISSUE until the next pop. It changes only on pop.
- Latency: a byte pushed into an empty, idle FIFO at edge N gives count = 1 after N. tx_enable is then high in the cycle following edge N+1, i.e. 2 clocks after the push edge.
- Back-to-back bytes: the next pop occurs the cycle after WAIT_DONE sees tx_busy low. Gap between frames is 3 cycles plus one line bit time, owned by the transmitter.
- Flush:
  - Sets wr_ptr = rd_ptr = count = 0 on the next edge.
  - Coincident push is dropped (flush wins).
  - Coincident pop is suppressed.
  - Does not abort a byte already issued. The FSM continues ISSUE/WAIT_BUSY/WAIT_DONE normally.
- Reset mid-operation: everything returns to reset values immediately. tx_enable drops asynchronously. Queued bytes are lost.
- tx_busy high in IDLE (transmitter driven by another master): no pop until it is low.
- Illegal state encodings return to IDLE with tx_enable = 0.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE).
  - UART byte width constant (8).
- One sub-module, uart_byte_fifo:
  - Generic DEPTH × 8 synchronous FIFO with push/pop/flush/count/empty/full.
- uart_tx_fifo instantiates uart_byte_fifo and adds the issue FSM and the tx_data/tx_enable registers.
- Integration test pairs uart_tx_fifo with the transmitter at CLK_HZ=100000000, BIT_RATE=9600.

Test Plan:
1. Reset values: after reset release, check s_ready=1, fifo_empty=1, fifo_count=0, tx_enable=0, tx_data=0; hold s_valid=0 for 20 cycles -> no tx_enable.
2. Single byte: push 0xA5 with tx_busy=0 -> tx_enable high exactly 1 cycle, 2 clocks after the push edge, with tx_data=0xA5. Model tx_busy high for 50 cycles -> no further tx_enable; fifo_count returns 0.
3. Fill and wrap: DEPTH=16, tx_busy held 1, push 0x00..0x0F -> fifo_full=1, s_ready=0, and a 17th push of 0xFF is not accepted. Release busy and model transmitter -> tx_data sequence 0x00..0x0F. Then push 16 more (0x10..0x1F) to exercise pointer wrap -> order preserved.
4. Simultaneous push/pop: count=3, push 0x55 on the same cycle IDLE pops -> count stays 3; 0x55 emerges after the existing 3 bytes.
5. Flush: 5 bytes queued, byte 0x11 in WAIT_DONE, assert flush with s_valid=1 and s_data=0x22 -> count=0, 0x22 dropped. 0x11 completes; no further tx_enable.
6. Reset mid-transfer: assert resetn=0 during ISSUE -> tx_enable=0 immediately, state IDLE, fifo_count=0 after release. Loopback with the real transmitter: line shows start bit, 0xA5 LSB-first, stop bit at 9600 baud.
